// File: rtl/runner_logic_if.sv
// Bundle between the game engine and runner_logic: frame strobe, obstacle
// stream and player controls flow in, player status flows back out.
interface runner_logic_if #(
  parameter int NUM_LANES = 3,
  parameter int LIVES     = 3
);
  localparam int LANE_W  = $clog2(NUM_LANES);
  localparam int LIVES_W = $clog2(LIVES + 1);

  logic               new_frame;
  logic [15:0]        obstacle;
  logic               obstacle_valid;
  logic               firstrow;
  logic               duck;
  logic               jump;
  logic               left;
  logic               right;
  logic               game_over;
  logic [LANE_W-1:0]  player_lane;
  logic signed [15:0] player_height;
  logic [23:0]        player_score;
  logic [1:0]         player_state;
  logic [LIVES_W-1:0] lives_left;
  logic [7:0]         speed;
  logic               hit;

  modport master (
    output new_frame, obstacle, obstacle_valid, firstrow, duck, jump, left, right,
    input  game_over, player_lane, player_height, player_score, player_state,
           lives_left, speed, hit
  );

  modport slave (
    input  new_frame, obstacle, obstacle_valid, firstrow, duck, jump, left, right,
    output game_over, player_lane, player_height, player_score, player_state,
           lives_left, speed, hit
  );
endinterface

// File: rtl/runner_logic.sv
// Endless-runner player logic: lane changes, jump/duck physics, obstacle
// collisions with lives and invulnerability, and score-driven speed-up.
module runner_logic #(
  parameter int NUM_LANES         = 3,
  parameter int HALF_BLOCK_LENGTH = 64,
  parameter int GRAVITY           = 3,
  parameter int VERTICAL_JUMP     = 10,
  parameter int DUCK_LIMIT        = 15,
  parameter int GROUND            = -128,
  parameter int MARGIN_OF_ERROR   = 10,
  parameter int SPEED_INIT        = 4,
  parameter int SPEED_MAX         = 16,
  parameter int SPEED_STEP        = 4096,
  parameter int LIVES             = 3,
  parameter int INVULN_FRAMES     = 60
) (
  input  logic          clk,
  input  logic          rst,
  runner_logic_if.slave bus
);
  localparam int LANE_W  = $clog2(NUM_LANES);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int INV_W   = $clog2(INVULN_FRAMES + 1);
  localparam int DUCK_W  = $clog2(DUCK_LIMIT + 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_AIR  = 2'd1;
  localparam logic [1:0] S_DUCK = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  localparam logic signed [15:0] GROUND_H = 16'(GROUND);
  localparam logic signed [15:0] HALF_H   = 16'(HALF_BLOCK_LENGTH);
  localparam logic signed [15:0] MID_H    = 16'(HALF_BLOCK_LENGTH / 2);
  localparam logic signed [15:0] MARGIN_H = 16'(MARGIN_OF_ERROR);
  localparam logic signed [15:0] JUMP_H   = 16'(VERTICAL_JUMP);
  localparam logic signed [7:0]  JUMP_V   = 8'(VERTICAL_JUMP);
  localparam logic signed [7:0]  GRAV_V   = 8'(GRAVITY);
  localparam logic [15:0]        HALF_P   = 16'(HALF_BLOCK_LENGTH);
  localparam logic [15:0]        MID_P    = 16'(HALF_BLOCK_LENGTH / 2);
  localparam logic [7:0]         SPEED_INIT_V = 8'(SPEED_INIT);
  localparam logic [7:0]         SPEED_MAX_V  = 8'(SPEED_MAX);
  localparam logic [23:0]        STEP_V       = 24'(SPEED_STEP);

  logic signed [15:0] height;
  logic signed [7:0]  velocity;
  logic [23:0]        score;
  logic [23:0]        next_step;
  logic [LANE_W-1:0]  lane;
  logic [1:0]         state;
  logic [LIVES_W-1:0] lives;
  logic [7:0]         speed;
  logic [7:0]         target_speed;
  logic [15:0]        progress;
  logic [INV_W-1:0]   invuln;
  logic [DUCK_W-1:0]  duck_cnt;
  logic               hit;
  logic               game_over;

  logic [2:0]         obs_type;
  logic               in_lane;
  logic signed [15:0] half_prog;
  logic signed [15:0] ground_level;
  logic               at_mid;
  logic               low_hit;
  logic               high_hit;
  logic               obs_coll;
  logic signed [7:0]  nv;
  logic signed [15:0] nv_h;
  logic signed [15:0] air_height;
  logic               frame;
  logic               fell;
  logic               collide;
  logic [23:0]        score_next;
  logic [15:0]        prog_sum;
  logic               wrap;
  logic               crossing;
  logic [8:0]         doubled;
  logic [7:0]         target_next;

  assign obs_type  = bus.obstacle[15:13];
  assign in_lane   = bus.obstacle_valid && bus.firstrow &&
                     (bus.obstacle[12:10] == 3'(lane)) && (state != S_DEAD);
  assign half_prog = $signed({1'b0, progress[15:1]});

  always_comb begin
    ground_level = GROUND_H;
    if (in_lane) begin
      case (obs_type)
        3'd4:    ground_level = GROUND_H + HALF_H;
        3'd5:    ground_level = (bus.obstacle[9:0] >= 10'd64) ? GROUND_H + half_prog
                                                              : GROUND_H + MID_H + half_prog;
        default: ground_level = GROUND_H;
      endcase
    end
  end

  assign at_mid   = (progress == MID_P);
  assign low_hit  = (height <= GROUND_H + MID_H);
  assign high_hit = (state != S_DUCK);

  always_comb begin
    obs_coll = 1'b0;
    if (in_lane) begin
      case (obs_type)
        3'd1:    obs_coll = at_mid && low_hit;
        3'd2:    obs_coll = at_mid && high_hit;
        3'd3:    obs_coll = at_mid && low_hit && high_hit;
        3'd4:    obs_coll = (height <= GROUND_H + HALF_H);
        3'd5:    obs_coll = (height < ground_level - MARGIN_H);
        default: obs_coll = 1'b0;
      endcase
    end
  end

  // A dive in the air is just a forced velocity; it then lands or crashes like a fall.
  assign nv         = bus.duck ? -JUMP_V : velocity - GRAV_V;
  assign nv_h       = {{8{nv[7]}}, nv};
  assign air_height = height + nv_h;
  assign frame      = bus.new_frame && (state != S_DEAD);
  assign fell       = frame && (state == S_AIR) && (air_height < ground_level - MARGIN_H);
  assign collide    = (obs_coll || fell) && (invuln == '0);

  assign score_next  = score + 24'(speed);
  assign prog_sum    = progress + 16'(speed);
  assign wrap        = (prog_sum >= HALF_P);
  assign crossing    = (score_next >= next_step);
  assign doubled     = {target_speed, 1'b0};
  assign target_next = !crossing ? target_speed :
                       (doubled > 9'(SPEED_MAX)) ? SPEED_MAX_V : doubled[7:0];

  // A non-invulnerable collision pre-empts everything else a frame would do this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      height       <= '0;
      velocity     <= '0;
      score        <= '0;
      next_step    <= STEP_V;
      lane         <= LANE_W'(NUM_LANES / 2);
      state        <= S_RUN;
      lives        <= LIVES_W'(LIVES);
      speed        <= SPEED_INIT_V;
      target_speed <= SPEED_INIT_V;
      progress     <= '0;
      invuln       <= '0;
      duck_cnt     <= '0;
      hit          <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (collide) begin
        hit      <= 1'b1;
        lives    <= lives - LIVES_W'(1);
        height   <= ground_level;
        velocity <= '0;
        if (lives == LIVES_W'(1)) begin
          state     <= S_DEAD;
          game_over <= 1'b1;
        end else begin
          state  <= S_RUN;
          invuln <= INV_W'(INVULN_FRAMES);
        end
      end else if (frame) begin
        score        <= score_next;
        progress     <= wrap ? '0 : prog_sum;
        target_speed <= target_next;
        if (crossing) next_step <= next_step + STEP_V;
        if (wrap) speed <= target_next;
        if (invuln != '0) invuln <= invuln - INV_W'(1);
        if (bus.left && lane != '0) lane <= lane - LANE_W'(1);
        else if (bus.right && lane != LANE_W'(NUM_LANES - 1)) lane <= lane + LANE_W'(1);
        case (state)
          S_RUN: begin
            if (bus.duck) begin
              state    <= S_DUCK;
              duck_cnt <= DUCK_W'(1);
              height   <= ground_level;
            end else if (bus.jump) begin
              state    <= S_AIR;
              velocity <= JUMP_V;
              height   <= height + JUMP_H;
            end else begin
              height <= ground_level;
            end
          end
          // Below the margin only gets here while invulnerable, so it lands as well.
          S_AIR: begin
            if (air_height >= ground_level) begin
              height   <= air_height;
              velocity <= nv;
            end else begin
              height   <= ground_level;
              velocity <= '0;
              state    <= S_RUN;
            end
          end
          S_DUCK: begin
            if (bus.jump) begin
              state    <= S_AIR;
              velocity <= JUMP_V;
              height   <= height + JUMP_H;
            end else if (duck_cnt < DUCK_W'(DUCK_LIMIT)) begin
              duck_cnt <= duck_cnt + DUCK_W'(1);
              height   <= ground_level;
            end else if (bus.duck) begin
              duck_cnt <= DUCK_W'(1);
            end else begin
              state <= S_RUN;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  assign bus.game_over     = game_over;
  assign bus.player_lane   = lane;
  assign bus.player_height = height;
  assign bus.player_score  = score;
  assign bus.player_state  = state;
  assign bus.lives_left    = lives;
  assign bus.speed         = speed;
  assign bus.hit           = hit;
endmodule
